// File: rtl/interface_hcsr04_uc_if.sv
// Handshake bundle between the HC-SR04 control unit and its surroundings.
// master: system/datapath side; slave: the control unit.
interface interface_hcsr04_uc_if;
    logic       medir;
    logic       echo;
    logic       fim_medida;
    logic       zera;
    logic       gera;
    logic       registra;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        output medir, echo, fim_medida,
        input  zera, gera, registra, pronto, erro, db_estado
    );

    modport slave (
        input  medir, echo, fim_medida,
        output zera, gera, registra, pronto, erro, db_estado
    );
endinterface

// File: rtl/interface_hcsr04_uc.sv
// HC-SR04 control unit: sequences clear, trigger, echo wait and capture,
// with one watchdog budget shared by the echo wait and the measurement.
module interface_hcsr04_uc #(
    parameter int TIMEOUT_CICLOS = 1500000
) (
    input logic                  clock,
    input logic                  reset,
    interface_hcsr04_uc_if.slave bus
);
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ENVIA_TRIGGER = 4'b0010,
        ESPERA_ECHO   = 4'b0011,
        MEDIDA        = 4'b0100,
        ARMAZENAMENTO = 4'b0101,
        FINAL_MEDIDA  = 4'b0110,
        ERRO          = 4'b1111
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox;
    logic [CW-1:0] r_cnt;
    logic          w_expirou;
    logic          w_espera;
    logic          r_zera;
    logic          r_gera;
    logic          r_registra;
    logic          r_pronto;
    logic          r_erro;

    assign w_expirou = (r_cnt == LIMITE);
    assign w_espera  = (r_estado == ESPERA_ECHO) || (r_estado == MEDIDA);

    // Progress events are tested before expiry so they win on the last cycle.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:       w_prox = bus.medir ? PREPARACAO : INICIAL;
            PREPARACAO:    w_prox = ENVIA_TRIGGER;
            ENVIA_TRIGGER: w_prox = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (bus.echo)      w_prox = MEDIDA;
                else if (w_expirou) w_prox = ERRO;
            end
            MEDIDA: begin
                if (bus.fim_medida) w_prox = ARMAZENAMENTO;
                else if (w_expirou) w_prox = ERRO;
            end
            ARMAZENAMENTO: w_prox = FINAL_MEDIDA;
            FINAL_MEDIDA:  w_prox = INICIAL;
            ERRO:          w_prox = bus.medir ? PREPARACAO : ERRO;
            default:       w_prox = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado   <= INICIAL;
            r_cnt      <= '0;
            r_zera     <= 1'b0;
            r_gera     <= 1'b0;
            r_registra <= 1'b0;
            r_pronto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado   <= w_prox;
            r_zera     <= (w_prox == PREPARACAO);
            r_gera     <= (w_prox == ENVIA_TRIGGER);
            r_registra <= (w_prox == ARMAZENAMENTO);
            r_pronto   <= (w_prox == FINAL_MEDIDA);
            r_erro     <= (w_prox == ERRO);
            if (!w_espera) begin
                r_cnt <= '0;
            end else if (!w_expirou) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.zera      = r_zera;
    assign bus.gera      = r_gera;
    assign bus.registra  = r_registra;
    assign bus.pronto    = r_pronto;
    assign bus.erro      = r_erro;
    assign bus.db_estado = r_estado;
endmodule
